decode_stage_m: RTL and testbench

- Registered, handshaked RV32 decode stage; next generation of the combinational control decoder.
- Sits between fetch and execute. Accepts one 32-bit instruction plus PC per handshake and presents a registered bundle of control signals.
- Adds optional M-extension decode with a parametrised multi-cycle stall, an illegal-instruction flag, and a pipeline flush.
- Drives 0 on every field the old decoder left as don't-care, so the output is fully deterministic.

---
 rtl/decode_stage_m_if.sv | 39 +++
 rtl/decode_stage_m.sv | 239 +++++++++++++++++++++++
 tb/tb_decode_stage_m.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_m_if.sv
// Handshake and decoded-bundle signals between fetch, decode and execute.
interface decode_stage_m_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            reg_we;
  logic            alu2_select;
  logic [5:0]      op_alu;
  logic            dmem_we;
  logic [2:0]      reg_wdata_select;
  logic [2:0]      imm_select;
  logic [3:0]      pc_select;
  logic            illegal;
  logic            busy;

  // Environment side: fetch drives the input half, execute the out_ready.
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, reg_we, alu2_select,
           op_alu, dmem_we, reg_wdata_select, imm_select, pc_select,
           illegal, busy
  );

  // Decode stage side.
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, reg_we, alu2_select,
           op_alu, dmem_we, reg_wdata_select, imm_select, pc_select,
           illegal, busy
  );
endinterface

// File: rtl/decode_stage_m.sv
// Registered, handshaked RV32I(+M) decode stage with multi-cycle M-op stall.
//
// state | meaning
// IDLE  | nothing held, ready for a new instruction
// WAIT  | M-op accepted, counting down its latency (busy=1)
// HOLD  | decoded bundle presented (out_valid=1) until consumed
module decode_stage_m #(
  parameter int XLEN    = 32,
  parameter bit EN_MEXT = 1'b1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input logic            clk,
  input logic            reset,
  decode_stage_m_if.slave bus
);

  localparam logic [3:0] MUL_L = 4'(MUL_LAT);
  localparam logic [3:0] DIV_L = 4'(DIV_LAT);

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b110000;
  localparam logic [5:0] ALU_SLL  = 6'b100000;
  localparam logic [5:0] ALU_SLT  = 6'b000010;
  localparam logic [5:0] ALU_SLTU = 6'b000011;
  localparam logic [5:0] ALU_XOR  = 6'b000100;
  localparam logic [5:0] ALU_SRL  = 6'b100101;
  localparam logic [5:0] ALU_SRA  = 6'b110101;
  localparam logic [5:0] ALU_OR   = 6'b000110;
  localparam logic [5:0] ALU_AND  = 6'b000111;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;

  state_t     state, state_next;
  logic [3:0] cnt;
  logic       rdy, vld, bsy;
  logic       accept;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       alt;

  logic       d_reg_we, d_alu2, d_dmem_we, d_illegal, d_mop;
  logic [5:0] d_op;
  logic [2:0] d_wsel, d_imm;
  logic [3:0] d_pc;
  logic [3:0] d_lat;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];
  assign alt    = bus.in_instr[30];
  assign accept = bus.in_valid && rdy;

  // Combinational instruction decode; anything not driven below is 0.
  always_comb begin
    d_reg_we  = 1'b0;
    d_alu2    = 1'b0;
    d_dmem_we = 1'b0;
    d_illegal = 1'b0;
    d_mop     = 1'b0;
    d_op      = ALU_ADD;
    d_wsel    = 3'b000;
    d_imm     = 3'b000;
    d_pc      = 4'b0000;
    case (opcode)
      7'b0010011: begin
        d_reg_we = 1'b1;
        d_alu2   = 1'b1;
        d_wsel   = 3'b001;
        case (funct3)
          3'b000:  d_op = ALU_ADD;
          3'b001:  begin d_op = ALU_SLL; d_imm = 3'b001; end
          3'b010:  d_op = ALU_SLT;
          3'b011:  d_op = ALU_SLTU;
          3'b100:  d_op = ALU_XOR;
          3'b101:  begin d_op = alt ? ALU_SRA : ALU_SRL; d_imm = 3'b001; end
          3'b110:  d_op = ALU_OR;
          default: d_op = ALU_AND;
        endcase
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          d_reg_we = 1'b1;
          d_wsel   = 3'b001;
          case (funct3)
            3'b000:  d_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  d_op = ALU_SLL;
            3'b010:  d_op = ALU_SLT;
            3'b011:  d_op = ALU_SLTU;
            3'b100:  d_op = ALU_XOR;
            3'b101:  d_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  d_op = ALU_OR;
            default: d_op = ALU_AND;
          endcase
        end else if (EN_MEXT && funct7 == 7'b0000001) begin
          d_reg_we = 1'b1;
          d_wsel   = 3'b001;
          d_op     = {3'b001, funct3};
          d_mop    = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      7'b0000011: begin
        d_reg_we = 1'b1;
        d_alu2   = 1'b1;
      end
      7'b0100011: begin
        d_dmem_we = 1'b1;
        d_alu2    = 1'b1;
        d_imm     = 3'b010;
      end
      7'b1100011: begin
        d_imm = 3'b011;
        case (funct3)
          3'b000:  begin d_op = ALU_SUB;  d_pc = 4'b0001; end
          3'b001:  begin d_op = ALU_SUB;  d_pc = 4'b0010; end
          3'b100:  begin d_op = ALU_SLT;  d_pc = 4'b0010; end
          3'b101:  begin d_op = ALU_SLT;  d_pc = 4'b0001; end
          3'b110:  begin d_op = ALU_SLTU; d_pc = 4'b0010; end
          3'b111:  begin d_op = ALU_SLTU; d_pc = 4'b0001; end
          default: d_illegal = 1'b1;
        endcase
      end
      7'b1100111: begin
        d_reg_we = 1'b1;
        d_alu2   = 1'b1;
        d_wsel   = 3'b010;
        d_pc     = 4'b0111;
      end
      7'b1101111: begin
        d_reg_we = 1'b1;
        d_wsel   = 3'b010;
        d_imm    = 3'b100;
        d_pc     = 4'b1000;
      end
      7'b0110111: begin
        d_reg_we = 1'b1;
        d_wsel   = 3'b011;
        d_imm    = 3'b101;
      end
      7'b0010111: begin
        d_reg_we = 1'b1;
        d_wsel   = 3'b100;
        d_imm    = 3'b101;
      end
      default: d_illegal = 1'b1;
    endcase
    // An illegal word presents an all-zero control bundle apart from the flag.
    if (d_illegal) begin
      d_reg_we  = 1'b0;
      d_alu2    = 1'b0;
      d_dmem_we = 1'b0;
      d_op      = ALU_ADD;
      d_wsel    = 3'b000;
      d_imm     = 3'b000;
      d_pc      = 4'b0000;
    end
  end

  assign d_lat = d_mop ? (funct3[2] ? DIV_L : MUL_L) : 4'd0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (d_lat != 4'd0) ? WAIT : HOLD;
      WAIT: if (cnt == 4'd1) state_next = HOLD;
      HOLD: begin
        if (accept)             state_next = (d_lat != 4'd0) ? WAIT : HOLD;
        else if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    rdy = 1'b0;
    vld = 1'b0;
    bsy = 1'b0;
    case (state)
      IDLE: rdy = !bus.flush;
      WAIT: bsy = 1'b1;
      HOLD: begin
        vld = 1'b1;
        rdy = bus.out_ready && !bus.flush;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.busy      = bsy;

  // Stall down-counter: loads the latency on accept, counts down in WAIT.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) cnt <= 4'd0;
    else if (accept)        cnt <= d_lat;
    else if (state == WAIT) cnt <= cnt - 4'd1;
  end

  // Bundle register: captured on accept, otherwise held stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_pc           <= '0;
      bus.out_instr        <= '0;
      bus.reg_we           <= 1'b0;
      bus.alu2_select      <= 1'b0;
      bus.op_alu           <= '0;
      bus.dmem_we          <= 1'b0;
      bus.reg_wdata_select <= '0;
      bus.imm_select       <= '0;
      bus.pc_select        <= '0;
      bus.illegal          <= 1'b0;
    end else if (accept) begin
      bus.out_pc           <= bus.in_pc;
      bus.out_instr        <= bus.in_instr;
      bus.reg_we           <= d_reg_we;
      bus.alu2_select      <= d_alu2;
      bus.op_alu           <= d_op;
      bus.dmem_we          <= d_dmem_we;
      bus.reg_wdata_select <= d_wsel;
      bus.imm_select       <= d_imm;
      bus.pc_select        <= d_pc;
      bus.illegal          <= d_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage_m.sv
// Bench for decode_stage_m: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_decode_stage_m;

  typedef struct packed {
    logic       illegal;
    logic       reg_we;
    logic       alu2;
    logic [5:0] op;
    logic       dmem_we;
    logic [2:0] wsel;
    logic [2:0] imm;
    logic [3:0] pc;
  } bundle_t;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 0;

  decode_stage_m_if #(.XLEN(32)) a_if ();
  decode_stage_m_if #(.XLEN(32)) b_if ();

  decode_stage_m #(.XLEN(32), .EN_MEXT(1'b1), .MUL_LAT(2), .DIV_LAT(8)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if)
  );
  decode_stage_m #(.XLEN(32), .EN_MEXT(1'b0), .MUL_LAT(2), .DIV_LAT(8)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [5:0] alu_code(input logic [2:0] f3, input bit alt);
    case (f3)
      3'd0: return alt ? 6'b110000 : 6'b000000;
      3'd1: return 6'b100000;
      3'd2: return 6'b000010;
      3'd3: return 6'b000011;
      3'd4: return 6'b000100;
      3'd5: return alt ? 6'b110101 : 6'b100101;
      3'd6: return 6'b000110;
      default: return 6'b000111;
    endcase
  endfunction

  function automatic bundle_t ref_decode(input logic [31:0] ins, input bit mext);
    bundle_t b;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    b = '0;
    opc = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (opc)
      7'h13: begin
        b.reg_we = 1; b.alu2 = 1; b.wsel = 3'd1;
        b.op = alu_code(f3, (f3 == 3'd5) && ins[30]);
        b.imm = (f3 == 3'd1 || f3 == 3'd5) ? 3'd1 : 3'd0;
      end
      7'h33: begin
        if (f7 == 7'h00 || f7 == 7'h20) begin
          b.reg_we = 1; b.wsel = 3'd1;
          b.op = alu_code(f3, ins[30] && (f3 == 3'd0 || f3 == 3'd5));
        end else if (mext && f7 == 7'h01) begin
          b.reg_we = 1; b.wsel = 3'd1; b.op = {3'b001, f3};
        end else b.illegal = 1;
      end
      7'h03: begin b.reg_we = 1; b.alu2 = 1; end
      7'h23: begin b.dmem_we = 1; b.alu2 = 1; b.imm = 3'd2; end
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) b.illegal = 1;
        else begin
          b.imm = 3'd3;
          b.op = (f3[2] == 1'b0) ? 6'b110000 : (f3[1] ? 6'b000011 : 6'b000010);
          b.pc = (f3[0] ^ f3[2]) ? 4'b0010 : 4'b0001;
        end
      end
      7'h67: begin b.reg_we = 1; b.alu2 = 1; b.wsel = 3'd2; b.pc = 4'b0111; end
      7'h6F: begin b.reg_we = 1; b.wsel = 3'd2; b.imm = 3'd4; b.pc = 4'b1000; end
      7'h37: begin b.reg_we = 1; b.wsel = 3'd3; b.imm = 3'd5; end
      7'h17: begin b.reg_we = 1; b.wsel = 3'd4; b.imm = 3'd5; end
      default: b.illegal = 1;
    endcase
    return b;
  endfunction

  function automatic int ref_lat(input logic [31:0] ins);
    if (ins[6:0] == 7'h33 && ins[31:25] == 7'h01) return ins[14] ? 8 : 2;
    return 0;
  endfunction

  // m_mode: 0 empty, 1 stalling, 2 presenting
  int          m_mode = 0;
  int          m_rem  = 0;
  bundle_t     m_b    = '0;
  logic [31:0] m_pc   = '0;
  logic [31:0] m_ins  = '0;

  function automatic bit model_ready();
    return !a_if.flush && (m_mode == 0 || (m_mode == 2 && a_if.out_ready));
  endfunction

  always @(posedge clk) begin
    bit acc;
    int l;
    if (reset) begin
      m_mode = 0; m_rem = 0; m_b = '0; m_pc = '0; m_ins = '0;
    end else if (a_if.flush) begin
      m_mode = 0; m_rem = 0;
    end else begin
      acc = a_if.in_valid && model_ready();
      if (m_mode == 1) begin
        m_rem--;
        if (m_rem == 0) m_mode = 2;
      end else if (m_mode == 2 && a_if.out_ready) m_mode = 0;
      if (acc) begin
        l = ref_lat(a_if.in_instr);
        m_b = ref_decode(a_if.in_instr, 1'b1);
        m_pc = a_if.in_pc;
        m_ins = a_if.in_instr;
        m_rem = l;
        m_mode = (l > 0) ? 1 : 2;
      end
    end
  end

  // Per-cycle comparison of DUT A against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("in_ready", a_if.in_ready, model_ready());
      check("out_valid", a_if.out_valid, m_mode == 2);
      check("busy", a_if.busy, m_mode == 1);
      if (m_mode == 2) begin
        check("out_pc", a_if.out_pc, m_pc);
        check("out_instr", a_if.out_instr, m_ins);
        check("illegal", a_if.illegal, m_b.illegal);
        check("reg_we", a_if.reg_we, m_b.reg_we);
        check("alu2_select", a_if.alu2_select, m_b.alu2);
        check("op_alu", a_if.op_alu, m_b.op);
        check("dmem_we", a_if.dmem_we, m_b.dmem_we);
        check("reg_wdata_select", a_if.reg_wdata_select, m_b.wsel);
        check("imm_select", a_if.imm_select, m_b.imm);
        check("pc_select", a_if.pc_select, m_b.pc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  f7;
    w = $urandom;
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h13;
      1, 2: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: f7 = 7'h00;
          1: f7 = 7'h20;
          2: f7 = 7'h01;
          default: f7 = 7'($urandom);
        endcase
        w[31:25] = f7;
      end
      3: w[6:0] = 7'h03;
      4: w[6:0] = 7'h23;
      5: w[6:0] = 7'h63;
      6: w[6:0] = 7'h67;
      7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h37;
      9: w[6:0] = 7'h17;
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_out_valid"}, a_if.out_valid, 0);
    check({pfx, "_busy"}, a_if.busy, 0);
    check({pfx, "_illegal"}, a_if.illegal, 0);
    check({pfx, "_op_alu"}, a_if.op_alu, 0);
    check({pfx, "_out_pc"}, a_if.out_pc, 0);
    check({pfx, "_out_instr"}, a_if.out_instr, 0);
    check({pfx, "_reg_we"}, a_if.reg_we, 0);
    check({pfx, "_alu2"}, a_if.alu2_select, 0);
    check({pfx, "_dmem_we"}, a_if.dmem_we, 0);
    check({pfx, "_wsel"}, a_if.reg_wdata_select, 0);
    check({pfx, "_imm"}, a_if.imm_select, 0);
    check({pfx, "_pc_sel"}, a_if.pc_select, 0);
    check({pfx, "_in_ready"}, a_if.in_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    a_if.in_valid = 0; a_if.in_instr = '0; a_if.in_pc = '0; a_if.flush = 0; a_if.out_ready = 0;
    b_if.in_valid = 0; b_if.in_instr = '0; b_if.in_pc = '0; b_if.flush = 0; b_if.out_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1;
    smp();
    check_all_zero("rst");
    check("rst_b_out_valid", b_if.out_valid, 0);

    // addi x1,x0,5
    nxt(); a_if.in_valid = 1; a_if.in_instr = 32'h00500093; a_if.in_pc = 32'h100;
    nxt(); a_if.in_valid = 0;
    smp();
    check("addi_valid", a_if.out_valid, 1);
    check("addi_op", a_if.op_alu, 6'b000000);
    check("addi_alu2", a_if.alu2_select, 1);
    check("addi_imm", a_if.imm_select, 3'b000);
    check("addi_wsel", a_if.reg_wdata_select, 3'b001);
    check("addi_we", a_if.reg_we, 1);
    check("addi_pc", a_if.out_pc, 32'h100);
    nxt(); a_if.out_ready = 1;

    // add then sub back to back
    nxt(); a_if.in_valid = 1; a_if.in_instr = 32'h002081B3; a_if.in_pc = 32'h200;
    smp(); check("b2b_rdy0", a_if.in_ready, 1);
    nxt(); a_if.in_instr = 32'h402081B3; a_if.in_pc = 32'h204;
    smp();
    check("b2b_valid1", a_if.out_valid, 1);
    check("b2b_add", a_if.op_alu, 6'b000000);
    check("b2b_rdy1", a_if.in_ready, 1);
    nxt(); a_if.in_valid = 0;
    smp();
    check("b2b_valid2", a_if.out_valid, 1);
    check("b2b_sub", a_if.op_alu, 6'b110000);
    check("model_sub", m_b.op, 6'b110000);
    check("b2b_rdy2", a_if.in_ready, 1);

    // mul with MUL_LAT=2
    nxt(); a_if.in_valid = 1; a_if.in_instr = 32'h022081B3; a_if.in_pc = 32'h300;
    for (int i = 0; i < 2; i++) begin
      nxt(); a_if.in_valid = 0;
      smp();
      check("mul_busy", a_if.busy, 1);
      check("mul_rdy", a_if.in_ready, 0);
      check("mul_novalid", a_if.out_valid, 0);
    end
    smp();
    check("mul_valid", a_if.out_valid, 1);
    check("mul_op", a_if.op_alu, 6'b001000);
    check("mul_busy_end", a_if.busy, 0);

    // mul on the EN_MEXT=0 instance: illegal, no stall
    nxt(); b_if.in_valid = 1; b_if.in_instr = 32'h022081B3; b_if.out_ready = 1;
    nxt(); b_if.in_valid = 0;
    smp();
    check("nom_valid", b_if.out_valid, 1);
    check("nom_busy", b_if.busy, 0);
    check("nom_illegal", b_if.illegal, 1);
    check("nom_we", b_if.reg_we, 0);
    check("nom_op", b_if.op_alu, 0);

    // beq held for 3 cycles
    nxt(); a_if.in_valid = 1; a_if.in_instr = 32'h00208463; a_if.in_pc = 32'h400; a_if.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      nxt(); a_if.in_instr = 32'h00500093;
      smp();
      check("beq_valid", a_if.out_valid, 1);
      check("beq_op", a_if.op_alu, 6'b110000);
      check("beq_pcsel", a_if.pc_select, 4'b0001);
      check("beq_imm", a_if.imm_select, 3'b011);
      check("beq_rdy", a_if.in_ready, 0);
      check("beq_opc", a_if.out_instr, 32'h00208463);
    end
    check("model_beq_pc", m_b.pc, 4'b0001);
    nxt(); a_if.in_valid = 0; a_if.out_ready = 1;
    nxt(); smp(); check("beq_released", a_if.out_valid, 0);

    // div with flush in stall cycle 4
    nxt(); a_if.in_valid = 1; a_if.in_instr = 32'h0220C1B3; a_if.in_pc = 32'h500;
    for (int i = 0; i < 3; i++) begin
      nxt(); a_if.in_valid = 0;
      smp(); check("div_busy", a_if.busy, 1);
    end
    nxt(); a_if.flush = 1; a_if.in_valid = 1; a_if.in_instr = 32'h00500093;
    smp(); check("flush_rdy", a_if.in_ready, 0);
    nxt(); a_if.flush = 0; a_if.in_valid = 0;
    smp();
    check("flush_valid", a_if.out_valid, 0);
    check("flush_busy", a_if.busy, 0);
    check("flush_rdy_after", a_if.in_ready, 1);
    repeat (10) nxt();
    smp(); check("div_never", a_if.out_valid, 0);

    // opcode 0x7F then reset in the HOLD cycle
    nxt(); a_if.in_valid = 1; a_if.in_instr = 32'h0000007F; a_if.in_pc = 32'h600; a_if.out_ready = 0;
    nxt(); a_if.in_valid = 0; reset = 1;
    smp();
    check("ill_valid", a_if.out_valid, 1);
    check("ill_flag", a_if.illegal, 1);
    check("ill_we", a_if.reg_we, 0);
    check("ill_dwe", a_if.dmem_we, 0);
    check("ill_pcsel", a_if.pc_select, 0);
    nxt(); reset = 0;
    smp();
    check_all_zero("ill_rst");

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      nxt();
      reset          = ($urandom_range(0, 399) == 0);
      a_if.flush     = ($urandom_range(0, 39) == 0);
      a_if.in_valid  = ($urandom_range(0, 3) != 0);
      a_if.in_instr  = rand_instr();
      a_if.in_pc     = $urandom;
      a_if.out_ready = ($urandom_range(0, 3) != 0);
    end
    nxt();
    reset = 0;
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
